matinv_check: RTL
=================

Name: matinv_check

Overview:
- Sequential checker that multiplies a fixed-point matrix by its claimed inverse and compares the product against identity within a tolerance.
- Sits downstream of the combinational matrix inverter, consuming the inverter's flattened input/output buses.
- Provides an in-hardware pass/fail result and a worst-case error, replacing host-side checking of printed hex dumps.
- Uses one shared multiply-accumulate (MAC) unit, iterated by an FSM.

Parameters:
- DATA_WIDTH, 16: element width; signed two's complement.
- BIN_POS, 8: fractional bits (Q format binary point position).
- MATRIX_SIZE, 3: N; matrices are N x N.
- TOL, 4: maximum allowed absolute error per product element, in LSBs.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- i_start  input  1  start pulse; sampled only in IDLE
- i_matrix  input  N*N*DATA_WIDTH  matrix A; element (r,c) at bits [(r*N+c)*DATA_WIDTH +: DATA_WIDTH]
- i_inv  input  N*N*DATA_WIDTH  claimed inverse B; same packing as i_matrix
- o_busy  output  1  high from the cycle after start is accepted until o_done
- o_done  output  1  one-cycle pulse when the check completes
- o_pass  output  1  result valid from o_done until the next accepted start
- o_max_err  output  DATA_WIDTH  largest absolute element error, unsigned, saturating

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - o_busy=0, o_done=0, o_pass=0, o_max_err=0.
  - Internal counters and accumulator cleared.
- Operand capture: on a clk edge in IDLE with i_start=1, i_matrix and i_inv are latched into internal registers. Later input changes have no effect on the run.
- FSM states:
  - IDLE: on i_start, go to MAC with r=c=k=0, acc=0, max_err=0.
  - MAC: one cycle per k.
    - acc += A[r][k]*B[k][c], using the full 2*DATA_WIDTH signed product.
    - acc width is 2*DATA_WIDTH+clog2(N)+1, so no overflow is possible.
    - After k=N-1, go to CMP.
  - CMP: one cycle.
    - p = acc >>> BIN_POS (arithmetic shift, i.e. floor).
    - e = (r==c) ? (1<<BIN_POS) : 0.
    - err = |p-e| at full width.
    - max_err = max(max_err, err).
    - Clear acc and k; advance c, wrapping to 0 and incrementing r.
    - After element (N-1,N-1), go to DONE; otherwise return to MAC.
  - DONE: one cycle.
    - o_done=1.
    - o_pass = (max_err <= TOL).
    - o_max_err = min(max_err, 2^DATA_WIDTH-1).
    - Return to IDLE.
- Latency:
  - Start accepted at edge 0; o_done is high in cycle N*N*(N+1)+1.
  - N=3: o_done in cycle 37. N=2: o_done in cycle 13.
- o_busy is high in all MAC/CMP cycles and low in DONE.
- While not in IDLE, i_start is ignored entirely: no restart, no queuing.
- i_start in the same cycle as o_done is ignored; it may be accepted from the next cycle.
- o_pass/o_max_err hold their values through IDLE. On the next accepted start they clear to 0 at the first MAC cycle.
- Reset asserted mid-run aborts the run with no o_done. A start after reset release behaves as a fresh run.
- Error comparison is exact-integer on the truncated product. Rounding mode is floor, never round-to-nearest.

Test Plan:
- N=3, Q8.8, A=B=identity (diagonal 0x0100), start pulse -> o_done exactly 37 cycles later, o_pass=1, o_max_err=0, o_busy high cycles 1..36.
- N=2, A=[[0x0200,0],[0,0x0400]], B=[[0x0080,0],[0,0x0040]] -> o_pass=1, o_max_err=0.
- N=2, A=identity, B=identity with B[0][0]=0x0103 -> o_max_err=3, o_pass=1; repeat with B[0][0]=0x0105 -> o_max_err=5, o_pass=0.
- Signed path, N=2: A=[[0,0x0100],[0xFF00,0]], B=[[0,0xFF00],[0x0100,0]] -> o_pass=1, o_max_err=0; also B=0 -> o_max_err=0x0100, o_pass=0.
- Second i_start at cycle 10 of a run, and a change to i_matrix at cycle 5 -> result and timing identical to the undisturbed run.
- rst pulsed at cycle 20 of a run -> all outputs 0 immediately (asynchronous), no o_done; a new start after release completes normally with correct result.

Source files
------------

// File: rtl/matinv_check.sv
// matinv_check: multiplies a matrix by its claimed inverse with one shared MAC
// and checks the product against identity within a tolerance.
module matinv_check #(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 3,
    parameter int TOL         = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         i_start,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] i_matrix,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] i_inv,
    output logic                                         o_busy,
    output logic                                         o_done,
    output logic                                         o_pass,
    output logic [DATA_WIDTH-1:0]                        o_max_err
);
    localparam int N  = MATRIX_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam int AW = 2*DW + $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N-1);
    localparam logic [AW:0] ONE = (AW+1)'(1) << BIN_POS;
    localparam logic [AW:0] TOL_W = (AW+1)'(TOL);

    typedef enum logic [1:0] {IDLE, MAC, CMP, DONE} state_t;
    state_t state, state_n;

    logic signed [DW-1:0] a [N][N];
    logic signed [DW-1:0] b [N][N];
    logic [CW-1:0] r, c, k;
    logic signed [AW-1:0] acc;
    logic [AW:0] max_err, diff, err, max_n;
    logic signed [2*DW-1:0] prod;
    logic last;

    always_ff @(posedge clk)
        if (state == IDLE && i_start)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a[i][j] <= i_matrix[(i*N+j)*DW +: DW];
                    b[i][j] <= i_inv[(i*N+j)*DW +: DW];
                end

    always_comb begin
        prod    = a[r][k] * b[k][c];
        diff    = {acc[AW-1], acc >>> BIN_POS} - (r == c ? ONE : '0);
        err     = diff[AW] ? -diff : diff;
        max_n   = err > max_err ? err : max_err;
        last    = r == LAST && c == LAST;
        state_n = state;
        case (state)
            IDLE:    state_n = i_start ? MAC : IDLE;
            MAC:     state_n = k == LAST ? CMP : MAC;
            CMP:     state_n = last ? DONE : MAC;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r         <= '0;
            c         <= '0;
            k         <= '0;
            acc       <= '0;
            max_err   <= '0;
            o_pass    <= 1'b0;
            o_max_err <= '0;
        end else if (state == IDLE && i_start) begin
            r         <= '0;
            c         <= '0;
            k         <= '0;
            acc       <= '0;
            max_err   <= '0;
            o_pass    <= 1'b0;
            o_max_err <= '0;
        end else if (state == MAC) begin
            acc <= acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
            k   <= k + CW'(1);
        end else if (state == CMP) begin
            acc     <= '0;
            k       <= '0;
            max_err <= max_n;
            c       <= c == LAST ? '0 : c + CW'(1);
            r       <= c == LAST ? r + CW'(1) : r;
            // Results are loaded on the final compare so they are visible alongside o_done
            if (last) begin
                o_pass    <= max_n <= TOL_W;
                o_max_err <= |max_n[AW:DW] ? '1 : max_n[DW-1:0];
            end
        end

    assign o_busy = state == MAC || state == CMP;
    assign o_done = state == DONE;
endmodule
